systolic_out_deskew: RTL and testbench



---
 rtl/systolic_out_deskew.sv | 143 ++++++++++++++
 tb/tb_systolic_out_deskew.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_out_deskew.sv
// systolic_out_deskew: re-aligns the skewed column outputs of the systolic
// array into whole rows and buffers them in a small FIFO with a valid/ready
// output handshake. Column j is delayed by N-1-j cycles so that all columns
// of one result row meet in the same cycle.
// Optional feature macro: DESKEW_ALIGN_CHECK_EN -- when defined, a row is only
// accepted if every delayed column valid is set; partial rows are discarded
// and flagged on align_err. When undefined, column 0's valid qualifies the row.
module systolic_out_deskew #(
  parameter int N     = 8,
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N*WIDTH-1:0]       in_data,
  input  logic [N-1:0]             in_valid,
  output logic [N*WIDTH-1:0]       out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     align_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [N-1:0][WIDTH-1:0] col_data;
  logic [N-1:0]            col_vld;

  for (genvar j = 0; j < N; j++) begin : g_col
    if (j == N - 1) begin : g_nodly
      assign col_data[j] = in_data[j*WIDTH +: WIDTH];
      assign col_vld[j]  = in_valid[j];
    end else begin : g_dly
      localparam int L = N - 1 - j;
      logic [L-1:0][WIDTH-1:0] data_q, data_d;
      logic [L-1:0]            vld_q, vld_d;

      // Shift the column result and its valid one stage per cycle.
      always_comb begin
        data_d    = data_q;
        vld_d     = vld_q;
        data_d[0] = in_data[j*WIDTH +: WIDTH];
        vld_d[0]  = in_valid[j];
        for (int k = 1; k < L; k++) begin
          data_d[k] = data_q[k-1];
          vld_d[k]  = vld_q[k-1];
        end
      end

      // Delay-line registers, cleared so no partial row survives a reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_q <= '0;
          vld_q  <= '0;
        end else begin
          data_q <= data_d;
          vld_q  <= vld_d;
        end
      end

      assign col_data[j] = data_q[L-1];
      assign col_vld[j]  = vld_q[L-1];
    end
  end

  logic [N*WIDTH-1:0] row_data;
  logic               row_valid;
  logic               align_set;

  assign row_data = col_data;

`ifdef DESKEW_ALIGN_CHECK_EN
  assign row_valid = &col_vld;
  assign align_set = (|col_vld) & ~row_valid;
`else
  logic unused_vld;
  assign unused_vld = ^col_vld[N-1:1];
  assign row_valid  = col_vld[0];
  assign align_set  = 1'b0;
`endif

  logic [DEPTH-1:0][N*WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]                 level_q, level_d;
  logic                          overflow_q, overflow_d;
  logic                          align_err_q, align_err_d;
  logic                          pop, full, wr_en, drop;

  // FIFO bookkeeping: a full FIFO still accepts a row if the head leaves in the same cycle.
  always_comb begin
    pop         = (level_q != '0) && out_ready;
    full        = (level_q == LW'(DEPTH));
    wr_en       = row_valid && (!full || pop);
    drop        = row_valid && full && !pop;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q | drop;
    align_err_d = align_err_q | align_set;
    if (wr_en) begin
      mem_d[wr_ptr_q] = row_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage, pointers, occupancy and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      align_err_q <= align_err_d;
    end
  end

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_systolic_out_deskew.sv
// Directed bench for systolic_out_deskew (N=8, WIDTH=16, DEPTH=4).
module tb_systolic_out_deskew;

  localparam int N = 8;
  localparam int W = 16;
  localparam int D = 4;
`ifdef DESKEW_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2:0]     level;
  logic           overflow;
  logic           align_err;

  systolic_out_deskew #(.N(N), .WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .align_err(align_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pops = 0;

  bit           row_en [256];
  logic [15:0]  row_base [256];
  bit           drop5 [256];
  logic [127:0] exp_q [$];

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_row(input logic [15:0] base, input bit drop);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < N; j++)
      r[j*16 +: 16] = (drop && j == 5) ? 16'h0 : base + 16'(j);
    return r;
  endfunction

  task automatic sched(input int c, input logic [15:0] base, input bit drop, input bit expect_out);
    row_en[c]   = 1'b1;
    row_base[c] = base;
    drop5[c]    = drop;
    if (expect_out) exp_q.push_back(exp_row(base, drop));
  endtask

  // Drive the skewed columns for the current cycle, score the handshake, advance one cycle.
  task automatic tick();
    logic [127:0] d;
    logic [7:0]   v;
    d = '0;
    v = '0;
    for (int j = 0; j < N; j++) begin
      int c0;
      c0 = cyc - j;
      if (c0 >= 0 && row_en[c0] && !(j == 5 && drop5[c0])) begin
        v[j]          = 1'b1;
        d[j*16 +: 16] = row_base[c0] + 16'(j);
      end
    end
    in_data  = d;
    in_valid = v;
    if (out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) check_val("unexp_row", 128'(out_valid), 128'(0));
      else check_val("row", out_data, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    foreach (row_en[i]) begin
      row_en[i] = 1'b0; row_base[i] = '0; drop5[i] = 1'b0;
    end

    // Reset state
    rst = 1'b1;
    run_to(2);
    check_val("rst_level", 128'(level), 128'(0));
    check_val("rst_valid", 128'(out_valid), 128'(0));
    check_val("rst_data", out_data, 128'(0));
    check_val("rst_ovf", 128'(overflow), 128'(0));
    check_val("rst_aerr", 128'(align_err), 128'(0));
    rst = 1'b0;

    // Single row at cycle 10: visible only in cycle 18
    out_ready = 1'b1;
    sched(10, 16'h0100, 1'b0, 1'b1);
    for (int c = 11; c <= 22; c++) begin
      run_to(c);
      check_val("t1_valid", 128'(out_valid), 128'(c == 18));
      if (c == 18) check_val("t1_data", out_data, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    end

    // 20 back-to-back rows from cycle 30
    for (int i = 0; i < 20; i++) sched(30 + i, 16'h1000 + 16'(i * 16), 1'b0, 1'b1);
    pops = 0;
    for (int c = 38; c <= 58; c++) begin
      run_to(c);
      check_val("t2_valid", 128'(out_valid), 128'(c <= 57));
      check_val("t2_lvl_le1", 128'(level <= 3'd1), 128'(1));
    end
    run_to(60);
    check_val("t2_pops", 128'(pops), 128'(20));

    // Overflow: 6 rows, ready low, DEPTH 4
    out_ready = 1'b0;
    pops = 0;
    for (int i = 0; i < 6; i++) sched(70 + i, 16'h2000 + 16'(i * 16), 1'b0, i < 4);
    run_to(81);
    check_val("t3_lvl81", 128'(level), 128'(4));
    check_val("t3_ovf81", 128'(overflow), 128'(0));
    run_to(82);
    check_val("t3_ovf82", 128'(overflow), 128'(1));
    check_val("t3_lvl82", 128'(level), 128'(4));
    run_to(84);
    check_val("t3_stable", out_data, exp_row(16'h2000, 1'b0));
    out_ready = 1'b1;
    run_to(90);
    check_val("t3_lvl_end", 128'(level), 128'(0));
    check_val("t3_valid_end", 128'(out_valid), 128'(0));
    check_val("t3_ovf_sticky", 128'(overflow), 128'(1));
    check_val("t3_pops", 128'(pops), 128'(4));

    // Reset to clear overflow
    rst = 1'b1;
    run_to(93);
    rst = 1'b0;
    check_val("rst2_ovf", 128'(overflow), 128'(0));

    // Full FIFO with simultaneous pop and write
    out_ready = 1'b0;
    pops = 0;
    for (int i = 0; i < 5; i++) sched(100 + i, 16'h3000 + 16'(i * 16), 1'b0, 1'b1);
    run_to(111);
    check_val("t4_lvl111", 128'(level), 128'(4));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("t4_lvl112", 128'(level), 128'(4));
    check_val("t4_ovf112", 128'(overflow), 128'(0));
    check_val("t4_head", out_data, exp_row(16'h3010, 1'b0));
    out_ready = 1'b1;
    run_to(120);
    check_val("t4_lvl_end", 128'(level), 128'(0));
    check_val("t4_pops", 128'(pops), 128'(5));

    // Column 5 missing for the middle row
    pops = 0;
    sched(130, 16'h4000, 1'b0, 1'b1);
    sched(131, 16'h4010, 1'b1, !ALIGN_CHK);
    sched(132, 16'h4020, 1'b0, 1'b1);
    run_to(145);
    check_val("t5_aerr", 128'(align_err), 128'(ALIGN_CHK));
    check_val("t5_pops", 128'(pops), ALIGN_CHK ? 128'(2) : 128'(3));
    check_val("t5_ovf", 128'(overflow), 128'(0));

    // Reset with 3 rows buffered and 2 in flight
    out_ready = 1'b0;
    pops = 0;
    sched(160, 16'h5000, 1'b0, 1'b0);
    sched(161, 16'h5010, 1'b0, 1'b0);
    sched(162, 16'h5020, 1'b0, 1'b0);
    sched(168, 16'h5030, 1'b0, 1'b0);
    sched(169, 16'h5040, 1'b0, 1'b0);
    run_to(170);
    check_val("t6_lvl_pre", 128'(level), 128'(3));
    foreach (row_en[i]) row_en[i] = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t6_level", 128'(level), 128'(0));
    check_val("t6_valid", 128'(out_valid), 128'(0));
    check_val("t6_data", out_data, 128'(0));
    check_val("t6_ovf", 128'(overflow), 128'(0));
    check_val("t6_aerr", 128'(align_err), 128'(0));
    out_ready = 1'b1;
    run_to(190);
    check_val("t6_pops", 128'(pops), 128'(0));
    check_val("t6_lvl_end", 128'(level), 128'(0));
    check_val("t6_aerr_end", 128'(align_err), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
